// File: rtl/dsm_capture_ctrl.sv
// dsm_capture_ctrl: sequences the CIC decimator (enable/rate), discards the
// post-start settling transient and buffers decimated samples in a small
// circular FIFO presented on a valid/ready output. All outputs are registered.
module dsm_capture_ctrl #(
    parameter int WIDTH        = 16,
    parameter int RATE_WIDTH   = 16,
    parameter int SETTLE_WIDTH = 8,
    parameter int DEPTH_LOG2   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [RATE_WIDTH-1:0]   rate_in,
    input  logic [SETTLE_WIDTH-1:0] settle_in,
    output logic                    cic_enable,
    output logic [RATE_WIDTH-1:0]   cic_rate,
    input  logic [WIDTH-1:0]        cic_data,
    input  logic                    cic_stb,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    overflow,
    output logic                    busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   ZERO_COUNT = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [RATE_WIDTH-1:0] MIN_RATE   = RATE_WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [SETTLE_WIDTH-1:0] settle_cnt_r;
    logic [SETTLE_WIDTH-1:0] settle_cnt_s;
    logic [RATE_WIDTH-1:0]   rate_s;
    logic                    capture_s;
    logic                    clear_ovf_s;

    logic [WIDTH-1:0]        mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_r;
    logic [DEPTH_LOG2-1:0]   rd_ptr_r;
    logic [DEPTH_LOG2-1:0]   wr_ptr_s;
    logic [DEPTH_LOG2-1:0]   rd_ptr_s;
    logic [DEPTH_LOG2:0]     count_r;
    logic [DEPTH_LOG2:0]     count_after_pop_s;
    logic [DEPTH_LOG2:0]     count_s;
    logic                    full_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    drop_s;
    logic                    overflow_s;
    logic [WIDTH-1:0]        head_s;

    // Capture sequencer: next state, settle countdown, rate latch and capture qualifier.
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        rate_s       = cic_rate;
        capture_s    = 1'b0;
        clear_ovf_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // start wins over stop here; stop alone has no effect
                if (start) begin
                    rate_s       = (rate_in < MIN_RATE) ? MIN_RATE : rate_in;
                    settle_cnt_s = settle_in;
                    clear_ovf_s  = 1'b1;
                    state_s      = (settle_in != {SETTLE_WIDTH{1'b0}}) ? SETTLE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_s = DRAIN;
                end else if (cic_stb) begin
                    // the strobe that reaches zero is itself still discarded
                    settle_cnt_s = settle_cnt_r - SETTLE_WIDTH'(1);
                    state_s      = (settle_cnt_r == SETTLE_WIDTH'(1)) ? RUN : SETTLE;
                end else begin
                    state_s = SETTLE;
                end
            end
            RUN: begin
                // a strobe coincident with stop is still captured
                capture_s = cic_stb;
                state_s   = stop ? DRAIN : RUN;
            end
            DRAIN: begin
                state_s = (count_r == ZERO_COUNT) ? IDLE : DRAIN;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: push/pop qualification, pointers, count, next head and overflow.
    always_comb begin
        full_s            = (count_r == FULL_COUNT);
        pop_s             = m_valid & m_ready;
        push_s            = capture_s & (~full_s | pop_s);
        drop_s            = capture_s & full_s & ~pop_s;
        rd_ptr_s          = rd_ptr_r + DEPTH_LOG2'(pop_s);
        wr_ptr_s          = wr_ptr_r + DEPTH_LOG2'(push_s);
        count_after_pop_s = count_r - (DEPTH_LOG2+1)'(pop_s);
        count_s           = count_after_pop_s + (DEPTH_LOG2+1)'(push_s);
        // a sample written into an otherwise empty FIFO bypasses the memory
        if (push_s && (count_after_pop_s == ZERO_COUNT)) begin
            head_s = cic_data;
        end else if (count_after_pop_s != ZERO_COUNT) begin
            head_s = mem_r[rd_ptr_s];
        end else begin
            head_s = m_data;
        end
        if (clear_ovf_s) begin
            overflow_s = 1'b0;
        end else if (drop_s) begin
            overflow_s = 1'b1;
        end else begin
            overflow_s = overflow;
        end
    end

    // Sample storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= cic_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // State, FIFO control and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            settle_cnt_r <= {SETTLE_WIDTH{1'b0}};
            wr_ptr_r     <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r     <= {DEPTH_LOG2{1'b0}};
            count_r      <= ZERO_COUNT;
            cic_enable   <= 1'b0;
            cic_rate     <= MIN_RATE;
            m_data       <= {WIDTH{1'b0}};
            m_valid      <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            count_r      <= count_s;
            cic_enable   <= (state_s == SETTLE) || (state_s == RUN);
            cic_rate     <= rate_s;
            m_data       <= head_s;
            m_valid      <= (count_s != ZERO_COUNT);
            overflow     <= overflow_s;
            busy         <= (state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_dsm_capture_ctrl.sv
// tb_dsm_capture_ctrl: directed test-plan scenarios followed by randomized
// traffic, every cycle compared against a queue-based behavioural model.
module tb_dsm_capture_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] rate_in;
    logic [7:0]  settle_in;
    logic        cic_enable;
    logic [15:0] cic_rate;
    logic [15:0] cic_data;
    logic        cic_stb;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        overflow;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // behavioural model: mode 0=idle 1=settle 2=run 3=drain
    int          md_mode;
    int          md_settle;
    logic [15:0] md_rate;
    bit          md_ovf;
    logic [15:0] md_q[$];

    dsm_capture_ctrl #(
        .WIDTH(16), .RATE_WIDTH(16), .SETTLE_WIDTH(8), .DEPTH_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .rate_in(rate_in), .settle_in(settle_in),
        .cic_enable(cic_enable), .cic_rate(cic_rate),
        .cic_data(cic_data), .cic_stb(cic_stb),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .overflow(overflow), .busy(busy)
    );

    // free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance the model by one rising edge using the inputs presented to the DUT
    task automatic model_step();
        int  sz;
        bit  pop;
        bit  push;
        if (!rst) begin
            md_mode = 0; md_settle = 0; md_rate = 16'd2; md_ovf = 1'b0;
            md_q.delete();
        end else begin
            sz   = md_q.size();
            pop  = (sz > 0) && m_ready;
            push = 1'b0;
            case (md_mode)
                0: if (start) begin
                    md_rate   = (rate_in < 16'd2) ? 16'd2 : rate_in;
                    md_settle = settle_in;
                    md_ovf    = 1'b0;
                    md_mode   = (settle_in != 8'd0) ? 1 : 2;
                end
                1: if (stop) md_mode = 3;
                   else if (cic_stb) begin
                       md_settle = md_settle - 1;
                       if (md_settle == 0) md_mode = 2;
                   end
                2: begin
                    if (cic_stb) begin
                        if (sz < 4 || pop) push = 1'b1;
                        else md_ovf = 1'b1;
                    end
                    if (stop) md_mode = 3;
                end
                3: if (sz == 0) md_mode = 0;
                default: md_mode = 0;
            endcase
            if (pop) void'(md_q.pop_front());
            if (push) md_q.push_back(cic_data);
        end
    endtask

    task automatic compare_all();
        check_eq("cic_enable", cic_enable, (md_mode == 1 || md_mode == 2));
        check_eq("cic_rate", cic_rate, md_rate);
        check_eq("busy", busy, (md_mode != 0));
        check_eq("m_valid", m_valid, (md_q.size() != 0));
        check_eq("overflow", overflow, md_ovf);
        if (md_q.size() != 0) check_eq("m_data", m_data, md_q[0]);
    endtask

    // one clock: drive inputs, take the edge, update model, sample 1 ns later
    task automatic cyc(input bit st, input bit sp, input bit sb, input logic [15:0] d, input bit rdy);
        start = st; stop = sp; cic_stb = sb; cic_data = d; m_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; cic_stb = 1'b0;
        cic_data = 16'd0; m_ready = 1'b0; rate_in = 16'd0; settle_in = 8'd0;
        md_mode = 0; md_settle = 0; md_rate = 16'd2; md_ovf = 1'b0;

        // reset values
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        check_eq("rst_m_data", m_data, 32'd0);
        check_eq("rst_rate", cic_rate, 32'd2);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);   // stop in idle is ignored

        // settle then capture
        rate_in = 16'd4; settle_in = 8'd3;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        check_eq("rate4", cic_rate, 32'd4);
        check_eq("en_after_start", cic_enable, 32'd1);
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 16'(i), 1'b1);
            check_eq("capt_valid", m_valid, (i >= 4) ? 32'd1 : 32'd0);
            if (i >= 4) check_eq("capt_data", m_data, 32'(i));
            cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        end
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
        check_eq("en_after_stop", cic_enable, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        check_eq("idle_busy", busy, 32'd0);

        // rate clamp with zero settle; first strobe captured
        rate_in = 16'd0; settle_in = 8'd0;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        check_eq("clamp", cic_rate, 32'd2);
        cyc(1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0);
        check_eq("zero_settle_data", m_data, 32'hABCD);

        // overflow: six strobes total with no reader
        for (int i = 2; i <= 6; i++) cyc(1'b0, 1'b0, 1'b1, 16'(16'h10 + i), 1'b0);
        check_eq("ovf_set", overflow, 32'd1);
        check_eq("ovf_head", m_data, 32'hABCD);
        // push and pop together while full
        cyc(1'b0, 1'b0, 1'b1, 16'h0077, 1'b1);
        check_eq("pp_head", m_data, 32'h0012);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        check_eq("ovf_sticky", overflow, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        rate_in = 16'd7;
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        check_eq("ovf_clear", overflow, 32'd0);

        // stop and drain with toggling ready; start during drain ignored
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 16'(16'h200 + i), 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        check_eq("drain_en", cic_enable, 32'd0);
        for (int i = 0; i < 10; i++) cyc(i == 2, 1'b0, 1'b1, 16'hDEAD, i[0]);
        check_eq("drain_done", busy, 32'd0);

        // reset mid-run with two entries queued
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0301, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h0302, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        check_eq("rstmid_valid", m_valid, 32'd0);
        check_eq("rstmid_data", m_data, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) != 0);
            rate_in   = 16'($urandom_range(0, 6));
            settle_in = 8'($urandom_range(0, 4));
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 1) == 0, 16'($urandom), $urandom_range(0, 4) < 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
